// File: rtl/gfx_pkg.sv
// Shared graphics types: integer points/triangles, screen defaults and the
// raster controller state encoding.
package gfx_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  // Fraction bits of the reciprocal and of the barycentric weights.
  localparam int FRAC_BITS    = 16;

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
  } int_point;

  typedef struct packed {
    int_point a;
    int_point b;
    int_point c;
  } int_triangle;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RECIP,
    ST_SCAN,
    ST_DRAIN
  } raster_state_e;

  function automatic logic signed [31:0] smin3(input logic signed [31:0] p,
                                               input logic signed [31:0] q,
                                               input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic signed [31:0] smax3(input logic signed [31:0] p,
                                               input logic signed [31:0] q,
                                               input logic signed [31:0] r);
    logic signed [31:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

endpackage

// File: rtl/raster_bbox.sv
// Triangle bounding box clipped to the screen. Purely combinational.
// A box that lies fully off-screen comes out with min > max and empty_o set.
module raster_bbox
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  int_triangle        tri_i,
  output logic signed [31:0] min_x_o,
  output logic signed [31:0] max_x_o,
  output logic signed [31:0] min_y_o,
  output logic signed [31:0] max_y_o,
  output logic               empty_o
);

  localparam logic signed [31:0] XMAX = 32'(SCREEN_W - 1);
  localparam logic signed [31:0] YMAX = 32'(SCREEN_H - 1);

  logic signed [31:0] lo_x, hi_x, lo_y, hi_y;

  // Raw extents, then clamp low side to 0 and high side to the last pixel.
  always_comb begin
    lo_x    = smin3(tri_i.a.x, tri_i.b.x, tri_i.c.x);
    hi_x    = smax3(tri_i.a.x, tri_i.b.x, tri_i.c.x);
    lo_y    = smin3(tri_i.a.y, tri_i.b.y, tri_i.c.y);
    hi_y    = smax3(tri_i.a.y, tri_i.b.y, tri_i.c.y);
    min_x_o = (lo_x < 32'sd0) ? 32'sd0 : lo_x;
    max_x_o = (hi_x > XMAX)   ? XMAX   : hi_x;
    min_y_o = (lo_y < 32'sd0) ? 32'sd0 : lo_y;
    max_y_o = (hi_y > YMAX)   ? YMAX   : hi_y;
    empty_o = (min_x_o > max_x_o) || (min_y_o > max_y_o);
  end

endmodule

// File: rtl/tri_raster_scan_ctrl.sv
// Per-triangle raster sequencer: accepts a triangle, clips its box, fetches
// 1/area and walks the box one point per cycle, emitting covered fragments
// through a single output register. Weights are Q(FRAC_BITS) and pass through.
module tri_raster_scan_ctrl
  import gfx_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tri_valid_i,
  output logic        tri_ready_o,
  input  int_triangle tri_i,
  output int_triangle calc_tri_o,
  output int_point    calc_point_o,
  output logic [31:0] calc_inv_o,
  input  logic [31:0] calc_edge_fn_i,
  input  logic [31:0] calc_wa_i,
  input  logic [31:0] calc_wb_i,
  input  logic [31:0] calc_wc_i,
  output logic        recip_req_o,
  output logic [31:0] recip_den_o,
  input  logic        recip_ack_i,
  input  logic [31:0] recip_result_i,
  output logic        frag_valid_o,
  input  logic        frag_ready_i,
  output logic [15:0] frag_x_o,
  output logic [15:0] frag_y_o,
  output logic [31:0] frag_wa_o,
  output logic [31:0] frag_wb_o,
  output logic [31:0] frag_wc_o,
  output logic        busy_o,
  output logic        tri_done_o
);

  raster_state_e      state_q;
  int_triangle        tri_q;
  int_point           point_q, pt_nx_d;
  logic [31:0]        inv_q, area_q;
  logic signed [31:0] min_x_q, max_x_q, min_y_q, max_y_q;
  logic               req_q, fv_q, busy_q, done_q, rdy_q;
  logic [15:0]        fx_q, fy_q;
  logic [31:0]        fwa_q, fwb_q, fwc_q;

  logic signed [31:0] bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic               bb_empty;
  logic               adv, covered, last_pt;

  raster_bbox #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_bbox (
    .tri_i   (tri_q),
    .min_x_o (bb_min_x),
    .max_x_o (bb_max_x),
    .min_y_o (bb_min_y),
    .max_y_o (bb_max_y),
    .empty_o (bb_empty)
  );

  // Output slot is free, or its fragment is being taken this cycle.
  assign adv     = !fv_q || frag_ready_i;
  // Sign bits clear on all three weights; zero weights (edges) count as inside.
  assign covered = !(calc_wa_i[31] || calc_wb_i[31] || calc_wc_i[31]);
  assign last_pt = (point_q.x == max_x_q) && (point_q.y == max_y_q);

  // Row-major successor of the current scan point.
  always_comb begin
    pt_nx_d = point_q;
    if (point_q.x == max_x_q) begin
      pt_nx_d.x = min_x_q;
      pt_nx_d.y = point_q.y + 32'sd1;
    end else begin
      pt_nx_d.x = point_q.x + 32'sd1;
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tri_q   <= '0;
      point_q <= '0;
      inv_q   <= '0;
      area_q  <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
      req_q   <= 1'b0;
      fv_q    <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      fwa_q   <= '0;
      fwb_q   <= '0;
      fwc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (tri_valid_i && rdy_q) begin
            tri_q   <= tri_i;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          area_q  <= calc_edge_fn_i;
          min_x_q <= bb_min_x;
          max_x_q <= bb_max_x;
          min_y_q <= bb_min_y;
          max_y_q <= bb_max_y;
          // Degenerate or fully off-screen: nothing to fetch or scan.
          if (calc_edge_fn_i == 32'd0 || bb_empty) begin
            state_q <= ST_DRAIN;
          end else begin
            req_q   <= 1'b1;
            state_q <= ST_RECIP;
          end
        end
        ST_RECIP: begin
          if (recip_ack_i) begin
            inv_q     <= recip_result_i;
            req_q     <= 1'b0;
            point_q.x <= min_x_q;
            point_q.y <= min_y_q;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (adv) begin
            fv_q  <= covered;
            fx_q  <= covered ? point_q.x[15:0] : 16'd0;
            fy_q  <= covered ? point_q.y[15:0] : 16'd0;
            fwa_q <= covered ? calc_wa_i : 32'd0;
            fwb_q <= covered ? calc_wb_i : 32'd0;
            fwc_q <= covered ? calc_wc_i : 32'd0;
            if (last_pt) state_q <= ST_DRAIN;
            else         point_q <= pt_nx_d;
          end
        end
        ST_DRAIN: begin
          if (adv) begin
            fv_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tri_ready_o  = rdy_q;
  assign calc_tri_o   = tri_q;
  assign calc_point_o = point_q;
  assign calc_inv_o   = inv_q;
  assign recip_req_o  = req_q;
  assign recip_den_o  = area_q;
  assign frag_valid_o = fv_q;
  assign frag_x_o     = fx_q;
  assign frag_y_o     = fy_q;
  assign frag_wa_o    = fwa_q;
  assign frag_wb_o    = fwb_q;
  assign frag_wc_o    = fwc_q;
  assign busy_o       = busy_q;
  assign tri_done_o   = done_q;

endmodule

// File: tb/tb_tri_raster_scan_ctrl.sv
// Bench for tri_raster_scan_ctrl: behavioural weight datapath and reciprocal
// unit around the DUT, reference fragment list built from the coverage rule.
module tb_tri_raster_scan_ctrl;
  import gfx_pkg::*;

  localparam int RLAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tri_valid;
  logic        tri_ready;
  int_triangle tri_in, calc_tri;
  int_point    calc_point;
  logic [31:0] calc_inv, calc_edge_fn, calc_wa, calc_wb, calc_wc;
  logic        recip_req, recip_ack;
  logic [31:0] recip_den, recip_result;
  logic        frag_valid, frag_ready;
  logic [15:0] frag_x, frag_y;
  logic [31:0] frag_wa, frag_wb, frag_wc;
  logic        busy, tri_done;

  always #5 clk = ~clk;

  tri_raster_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid_i(tri_valid), .tri_ready_o(tri_ready), .tri_i(tri_in),
    .calc_tri_o(calc_tri), .calc_point_o(calc_point), .calc_inv_o(calc_inv),
    .calc_edge_fn_i(calc_edge_fn), .calc_wa_i(calc_wa), .calc_wb_i(calc_wb),
    .calc_wc_i(calc_wc),
    .recip_req_o(recip_req), .recip_den_o(recip_den),
    .recip_ack_i(recip_ack), .recip_result_i(recip_result),
    .frag_valid_o(frag_valid), .frag_ready_i(frag_ready),
    .frag_x_o(frag_x), .frag_y_o(frag_y),
    .frag_wa_o(frag_wa), .frag_wb_o(frag_wb), .frag_wc_o(frag_wc),
    .busy_o(busy), .tri_done_o(tri_done)
  );

  // ---------------- environment: weight datapath and reciprocal ----------
  function automatic int edgef(int ax, int ay, int bx, int by, int px, int py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic logic [31:0] wmul(int e, int inv);
    longint p;
    p = longint'(e) * longint'(inv);
    return p[31:0];
  endfunction

  function automatic int recip_of(int den);
    return 65536 / den;
  endfunction

  assign calc_edge_fn = edgef(calc_tri.a.x, calc_tri.a.y, calc_tri.b.x, calc_tri.b.y,
                              calc_tri.c.x, calc_tri.c.y);
  assign calc_wa = wmul(edgef(calc_tri.b.x, calc_tri.b.y, calc_tri.c.x, calc_tri.c.y,
                              calc_point.x, calc_point.y), $signed(calc_inv));
  assign calc_wb = wmul(edgef(calc_tri.c.x, calc_tri.c.y, calc_tri.a.x, calc_tri.a.y,
                              calc_point.x, calc_point.y), $signed(calc_inv));
  assign calc_wc = wmul(edgef(calc_tri.a.x, calc_tri.a.y, calc_tri.b.x, calc_tri.b.y,
                              calc_point.x, calc_point.y), $signed(calc_inv));

  int rcnt = 0;
  // Reciprocal unit: one-cycle ack RLAT cycles after the request is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      rcnt = 0;
      recip_ack = 1'b0;
    end else if (recip_ack) begin
      recip_ack = 1'b0;
      rcnt = 0;
    end else if (recip_req) begin
      rcnt++;
      if (rcnt >= RLAT) begin
        recip_ack    = 1'b1;
        recip_result = recip_of($signed(recip_den));
        rcnt = 0;
      end
    end else begin
      rcnt = 0;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    int x, y;
    logic [31:0] wa, wb, wc;
  } frag_t;
  frag_t exp_q[$];

  function automatic int imin3(int p, int q, int r);
    int m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction
  function automatic int imax3(int p, int q, int r);
    int m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  // Expected fragment list: every pixel of the clipped box, row-major, whose
  // three barycentric weights are non-negative.
  task automatic build_ref(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, output int n_rec, output int box_pts);
    int area, inv, lx, hx, ly, hy;
    frag_t f;
    exp_q.delete();
    n_rec = 0;
    box_pts = 0;
    area = edgef(ax, ay, bx, by, cx, cy);
    lx = imin3(ax, bx, cx); if (lx < 0) lx = 0;
    ly = imin3(ay, by, cy); if (ly < 0) ly = 0;
    hx = imax3(ax, bx, cx); if (hx > SCREEN_W_DEF - 1) hx = SCREEN_W_DEF - 1;
    hy = imax3(ay, by, cy); if (hy > SCREEN_H_DEF - 1) hy = SCREEN_H_DEF - 1;
    if (area != 0 && lx <= hx && ly <= hy) begin
      n_rec = 1;
      box_pts = (hx - lx + 1) * (hy - ly + 1);
      inv = recip_of(area);
      for (int y = ly; y <= hy; y++)
        for (int x = lx; x <= hx; x++) begin
          f.x = x; f.y = y;
          f.wa = wmul(edgef(bx, by, cx, cy, x, y), inv);
          f.wb = wmul(edgef(cx, cy, ax, ay, x, y), inv);
          f.wc = wmul(edgef(ax, ay, bx, by, x, y), inv);
          if (!f.wa[31] && !f.wb[31] && !f.wc[31]) exp_q.push_back(f);
        end
    end
  endtask

  // ---------------- fragment sink / monitor ----------------
  int rdy_mode = 0, pat_ph = 0;
  int got_cnt = 0, done_cnt = 0, rec_cnt = 0;
  logic stall_q = 1'b0, req_prev = 1'b0;
  logic [255:0] held;

  always @(negedge clk) begin
    frag_t e;
    case (rdy_mode)
      0: frag_ready = 1'b1;
      1: begin frag_ready = (pat_ph == 0 || pat_ph == 3); pat_ph = (pat_ph + 1) % 4; end
      default: frag_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst_n) begin
      stall_q  = 1'b0;
      req_prev = 1'b0;
    end else begin
      if (stall_q)
        chk("hold", {frag_valid, frag_x, frag_y, frag_wa, frag_wb, frag_wc, calc_point}, held);
      if (frag_valid && frag_ready) begin
        got_cnt++;
        if (exp_q.size() == 0) chk("extra_frag", {frag_x, frag_y}, 0);
        else begin
          e = exp_q.pop_front();
          chk("frag_xy", {frag_x, frag_y}, {16'(e.x), 16'(e.y)});
          chk("frag_w", {frag_wa, frag_wb, frag_wc}, {e.wa, e.wb, e.wc});
        end
      end
      stall_q = frag_valid && !frag_ready;
      held = {frag_valid, frag_x, frag_y, frag_wa, frag_wb, frag_wc, calc_point};
      if (tri_done) done_cnt++;
      if (recip_req && !req_prev) rec_cnt++;
      req_prev = recip_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_tri(input int ax, input int ay, input int bx, input int by,
                          input int cx, input int cy);
    int n;
    n = 0;
    while (!tri_ready && n < 50) begin @(negedge clk); n++; end
    chk("tri_ready_wait", tri_ready, 1);
    tri_in.a.x = ax; tri_in.a.y = ay;
    tri_in.b.x = bx; tri_in.b.y = by;
    tri_in.c.x = cx; tri_in.c.y = cy;
    tri_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int mode, output int got);
    int n_rec, box_pts, exp_n, n;
    build_ref(ax, ay, bx, by, cx, cy, n_rec, box_pts);
    exp_n = exp_q.size();
    rdy_mode = mode; pat_ph = 0;
    got_cnt = 0; done_cnt = 0; rec_cnt = 0;
    send_tri(ax, ay, bx, by, cx, cy);
    n = 0;
    while (!tri_done && n < 5000) begin @(negedge clk); n++; end
    chk("done_seen", tri_done, 1);
    repeat (2) @(negedge clk);
    chk("frag_cnt", got_cnt, exp_n);
    chk("exp_left", exp_q.size(), 0);
    chk("done_cnt", done_cnt, 1);
    chk("recip_cnt", rec_cnt, n_rec);
    if (n_rec == 0) chk("degen_lat", n <= 3, 1);
    if (mode == 0 && n_rec != 0) chk("rate", n <= box_pts + 10, 1);
    got = got_cnt;
  endtask

  initial begin
    int got, n;
    rst_n = 1'b0; tri_valid = 1'b0; tri_in = '0;
    frag_ready = 1'b0; recip_ack = 1'b0; recip_result = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl", {tri_ready, busy, frag_valid, recip_req, tri_done}, 0);
    chk("rst_data", {frag_x, frag_y, frag_wa, frag_wb, frag_wc, recip_den, calc_inv, calc_point}, 0);
    chk("rst_tri", calc_tri, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {tri_ready, busy}, 2'b10);

    run_tri(0, 0, 4, 0, 0, 4, 0, got);      chk("right_cnt", got, 15);
    run_tri(0, 0, 0, 4, 4, 0, 0, got);      chk("rev_wind_cnt", got, 15);
    run_tri(0, 0, 2, 2, 5, 5, 0, got);      chk("collinear_cnt", got, 0);
    run_tri(-3, -3, 5, -3, -3, 5, 0, got);  chk("clip_cnt", got, 6);
    run_tri(-3, -3, 2, -3, -3, 2, 0, got);
    run_tri(-10, -10, -5, -10, -10, -5, 0, got);
    run_tri(630, 10, 660, 10, 630, 30, 0, got);
    run_tri(5, 470, 20, 495, 0, 490, 0, got);
    run_tri(0, 0, 4, 0, 0, 4, 1, got);      chk("stall_cnt", got, 15);

    // Abort mid-scan with a one-cycle reset.
    rdy_mode = 0; done_cnt = 0;
    send_tri(0, 0, 4, 0, 0, 4);
    n = 0;
    while (!frag_valid && n < 50) begin @(negedge clk); n++; end
    chk("abort_scan_reached", frag_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {tri_ready, busy, frag_valid, recip_req, tri_done}, 0);
    chk("abort_data", {frag_x, frag_y, frag_wa, frag_wb, frag_wc, recip_den, calc_inv, calc_point}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); done_cnt = 0;
    @(negedge clk);
    chk("abort_rdy", {tri_ready, busy, frag_valid, tri_done}, 4'b1000);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    run_tri(0, 0, 4, 0, 0, 4, 0, got);      chk("post_abort_cnt", got, 15);

    for (int i = 0; i < 10; i++) begin
      int v[6], ox, oy;
      ox = ($urandom_range(0, 3) == 0) ? 620 : 0;
      oy = ($urandom_range(0, 3) == 0) ? 455 : 0;
      for (int k = 0; k < 6; k++) v[k] = int'($urandom_range(0, 32)) - 8;
      run_tri(v[0] + ox, v[1] + oy, v[2] + ox, v[3] + oy, v[4] + ox, v[5] + oy, 2, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
